// File: rtl/cla_pkg.sv
// Shared constants and FSM state type for the CLA adder stage and its result accumulator.
package cla_pkg;

  localparam int WIDTH     = 10;
  localparam int FRAME_LEN = 16;
  localparam int CNT_WIDTH = $clog2(FRAME_LEN) + 1;
  localparam int ACC_WIDTH = WIDTH + 1 + $clog2(FRAME_LEN);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

endpackage

// File: rtl/cla_result_accumulator.sv
// Sums frames of FRAME_LEN unsigned adder results (or a shorter flushed frame) and
// holds each frame sum until the downstream consumer takes it.
module cla_result_accumulator
  import cla_pkg::*;
#(
  parameter int WIDTH     = cla_pkg::WIDTH,
  parameter int FRAME_LEN = cla_pkg::FRAME_LEN
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst,
  input  logic [WIDTH:0]                         i_result,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic                                   i_flush,
  output logic [WIDTH+$clog2(FRAME_LEN):0]       o_sum,
  output logic [$clog2(FRAME_LEN):0]             o_count,
  output logic                                   o_valid,
  input  logic                                   i_ready
);

  localparam int CNT_WIDTH = $clog2(FRAME_LEN) + 1;
  localparam int ACC_WIDTH = WIDTH + 1 + $clog2(FRAME_LEN);

  state_e                 state;
  logic [ACC_WIDTH-1:0]   acc;
  logic [CNT_WIDTH-1:0]   cnt;

  logic                   accept;
  logic                   full;
  logic                   close;
  logic [ACC_WIDTH-1:0]   acc_next;
  logic [CNT_WIDTH-1:0]   cnt_next;

  // Ready is gated by reset so no sample can slip in while the block is being cleared.
  assign o_ready  = (state == ACCUM) && !i_rst;
  assign accept   = i_valid && o_ready;
  assign acc_next = accept ? acc + {{(ACC_WIDTH-WIDTH-1){1'b0}}, i_result} : acc;
  assign cnt_next = cnt + CNT_WIDTH'(accept);
  assign full     = accept && (cnt_next == CNT_WIDTH'(FRAME_LEN));
  // A flush only closes a frame that will contain at least one sample.
  assign close    = full || (i_flush && ((cnt != '0) || accept));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= ACCUM;
      acc     <= '0;
      cnt     <= '0;
      o_sum   <= '0;
      o_count <= '0;
      o_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          acc <= acc_next;
          cnt <= cnt_next;
          if (close) begin
            o_sum   <= acc_next;
            o_count <= cnt_next;
            o_valid <= 1'b1;
            state   <= HOLD;
          end
        end
        HOLD: begin
          // o_valid is always set here, so i_ready alone completes the handshake.
          if (i_ready) begin
            acc     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            state   <= ACCUM;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_result_accumulator.sv
// Directed bench for cla_result_accumulator with default parameters (WIDTH=10, FRAME_LEN=16).
module tb_cla_result_accumulator;

  logic        i_clk;
  logic        i_rst;
  logic [10:0] i_result;
  logic        i_valid;
  logic        o_ready;
  logic        i_flush;
  logic [14:0] o_sum;
  logic [4:0]  o_count;
  logic        o_valid;
  logic        i_ready;

  int n_checks;
  int n_pass;

  cla_result_accumulator dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_result (i_result),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_flush  (i_flush),
    .o_sum    (o_sum),
    .o_count  (o_count),
    .o_valid  (o_valid),
    .i_ready  (i_ready)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Presents one sample, waits (bounded) for o_ready, and returns just after the accepting edge.
  task automatic send(input logic [10:0] value, input logic flush);
    int waits;
    i_result = value;
    i_valid  = 1'b1;
    i_flush  = flush;
    waits    = 0;
    while (!o_ready && waits < 50) begin
      step();
      waits++;
    end
    if (!o_ready) check("ready_timeout", 32'(o_ready), 32'd1);
    step();
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    i_rst    = 1'b1;
    i_result = '0;
    i_valid  = 1'b0;
    i_flush  = 1'b0;
    i_ready  = 1'b1;

    // Reset state
    step();
    step();
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_sum",   32'(o_sum),   32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    i_rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(o_ready), 32'd1);

    // Sixteen samples of 1
    for (int i = 0; i < 15; i++) send(11'd1, 1'b0);
    check("ones_no_early_valid", 32'(o_valid), 32'd0);
    send(11'd1, 1'b0);
    check("ones_valid", 32'(o_valid), 32'd1);
    check("ones_sum",   32'(o_sum),   32'd16);
    check("ones_count", 32'(o_count), 32'd16);
    check("ones_ready_hold", 32'(o_ready), 32'd0);
    step();
    check("ones_handshake_clear", 32'(o_valid), 32'd0);
    check("ones_ready_back", 32'(o_ready), 32'd1);

    // Maximum samples: 16 * 2046
    for (int i = 0; i < 16; i++) send(11'd2046, 1'b0);
    check("max_sum",   32'(o_sum),   32'd32736);
    check("max_count", 32'(o_count), 32'd16);
    step();

    // Flush together with the third sample
    send(11'd5, 1'b0);
    send(11'd6, 1'b0);
    send(11'd7, 1'b1);
    check("flush_valid", 32'(o_valid), 32'd1);
    check("flush_sum",   32'(o_sum),   32'd18);
    check("flush_count", 32'(o_count), 32'd3);
    step();

    // Backpressure: frame of 3s completes with i_ready low, next sample held upstream
    i_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(11'd3, 1'b0);
    i_result = 11'd7;
    i_valid  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(o_valid), 32'd1);
      check("bp_sum",   32'(o_sum),   32'd48);
      check("bp_count", 32'(o_count), 32'd16);
      check("bp_ready", 32'(o_ready), 32'd0);
      step();
    end
    i_ready = 1'b1;
    step();
    check("bp_released", 32'(o_valid), 32'd0);
    for (int i = 0; i < 16; i++) send(11'd7, 1'b0);
    check("bp_next_sum",   32'(o_sum),   32'd112);
    check("bp_next_count", 32'(o_count), 32'd16);
    step();

    // Flush with an empty frame is ignored, then flush in HOLD is ignored
    i_flush = 1'b1;
    step();
    check("empty_flush_1", 32'(o_valid), 32'd0);
    step();
    check("empty_flush_2", 32'(o_valid), 32'd0);
    i_flush = 1'b0;
    i_ready = 1'b0;
    send(11'd4, 1'b0);
    send(11'd4, 1'b1);
    check("pre_hold_sum", 32'(o_sum), 32'd8);
    i_flush = 1'b1;
    step();
    step();
    check("hold_flush_valid", 32'(o_valid), 32'd1);
    check("hold_flush_sum",   32'(o_sum),   32'd8);
    check("hold_flush_count", 32'(o_count), 32'd2);
    i_flush = 1'b0;
    i_ready = 1'b1;
    step();
    check("hold_flush_released", 32'(o_valid), 32'd0);

    // Reset mid-frame discards the partial sum
    for (int i = 0; i < 7; i++) send(11'd1, 1'b0);
    i_rst = 1'b1;
    step();
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_sum",   32'(o_sum),   32'd0);
    i_rst = 1'b0;
    #1;
    for (int i = 0; i < 15; i++) send(11'd1, 1'b0);
    check("midrst_no_early", 32'(o_valid), 32'd0);
    send(11'd1, 1'b0);
    check("midrst_valid_out", 32'(o_valid), 32'd1);
    check("midrst_sum_out",   32'(o_sum),   32'd16);
    check("midrst_count_out", 32'(o_count), 32'd16);
    step();
    check("midrst_single", 32'(o_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
